// File: rtl/cvxif_issuer.sv
// Core-side CV-X-IF initiator: one offload command walks issue -> register -> result -> response.
// Optional result timeout is compiled in with `define CVXIF_ISSUER_TIMEOUT_EN.
module cvxif_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_instr,
  input  logic [31:0] cmd_rs0,
  input  logic [31:0] cmd_rs1,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] issue_req_instr,
  input  logic        issue_resp_accept,
  input  logic        issue_resp_writeback,
  input  logic [1:0]  issue_resp_register_read,
  output logic        register_valid,
  input  logic        register_ready,
  output logic [31:0] register_rs0,
  output logic [31:0] register_rs1,
  output logic [1:0]  register_rs_valid,
  input  logic        result_valid,
  output logic        result_ready,
  input  logic [31:0] result_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        rsp_writeback
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_REG,
    S_RESULT,
    S_RESP
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_REJ = 2'b01;

  state_t state;
  logic   wb_lat;

`ifdef CVXIF_ISSUER_TIMEOUT_EN
  localparam logic [1:0]       ST_TO    = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Counter is zero on every RESULT entry and advances while the result is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state != S_RESULT) begin
      cnt <= '0;
    end else if (!result_valid) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  // All handshake outputs are registered alongside the state, so none depends on an input combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      wb_lat            <= 1'b0;
      cmd_ready         <= 1'b0;
      issue_valid       <= 1'b0;
      issue_req_instr   <= '0;
      register_valid    <= 1'b0;
      register_rs0      <= '0;
      register_rs1      <= '0;
      register_rs_valid <= '0;
      result_ready      <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      rsp_status        <= '0;
      rsp_writeback     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // cmd_ready first rises one cycle after reset release.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            issue_req_instr <= cmd_instr;
            register_rs0    <= cmd_rs0;
            register_rs1    <= cmd_rs1;
            cmd_ready       <= 1'b0;
            issue_valid     <= 1'b1;
            state           <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            if (!issue_resp_accept) begin
              rsp_valid     <= 1'b1;
              rsp_status    <= ST_REJ;
              rsp_data      <= '0;
              rsp_writeback <= 1'b0;
              state         <= S_RESP;
            end else begin
              wb_lat <= issue_resp_writeback;
              if (issue_resp_register_read != 2'b00) begin
                register_valid    <= 1'b1;
                register_rs_valid <= issue_resp_register_read;
                state             <= S_REG;
              end else begin
                result_ready <= 1'b1;
                state        <= S_RESULT;
              end
            end
          end
        end

        S_REG: begin
          // Early result_valid also ends this phase for responders that never raise register_ready.
          if (register_ready || result_valid) begin
            register_valid    <= 1'b0;
            register_rs_valid <= '0;
            result_ready      <= 1'b1;
            state             <= S_RESULT;
          end
        end

        S_RESULT: begin
          if (result_valid) begin
            result_ready  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_data      <= result_data;
            rsp_status    <= ST_OK;
            rsp_writeback <= wb_lat;
            state         <= S_RESP;
          end
`ifdef CVXIF_ISSUER_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            result_ready  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_data      <= '0;
            rsp_status    <= ST_TO;
            rsp_writeback <= 1'b0;
            state         <= S_RESP;
          end
`endif
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_status    <= ST_OK;
            rsp_writeback <= 1'b0;
            cmd_ready     <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
